// File: rtl/alu_seq_if.sv
// Handshake and operand bus between the control unit and alu_seq.
// The control unit takes the master side; the ALU takes the slave side.
interface alu_seq_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             InValid;
   logic             InReady;
   logic [4:0]       FunSel;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [SHW-1:0]   ShAmt;
   logic             WF;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] ALUOut;
   logic [3:0]       FlagsOut;

   modport master (
      output InValid, FunSel, A, B, ShAmt, WF, OutReady,
      input  InReady, OutValid, ALUOut, FlagsOut
   );

   modport slave (
      input  InValid, FunSel, A, B, ShAmt, WF, OutReady,
      output InReady, OutValid, ALUOut, FlagsOut
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags {Z,C,N,O}; shifts and rotates
// advance one bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready; accepts an op, computes non-shift ops on that edge
//   S_SHIFT | stepping the working register one bit per edge
//   S_DONE  | result valid, held until the consumer takes it
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic     Clock,
   input logic     Reset,
   alu_seq_if.slave bus
);
   localparam int HALF = WIDTH / 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [WIDTH-1:0] MASK_FULL = '1;
   localparam logic [WIDTH-1:0] MASK_HALF = {{HALF{1'b0}}, {HALF{1'b1}}};
   localparam logic [WIDTH-1:0] TOP_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] TOP_HALF  = {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};

   logic [1:0]       state;
   logic [3:0]       code_q;
   logic             full_q;
   logic             wf_q;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] alu_out;
   logic [3:0]       flags;

   function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic full);
      return full ? v[WIDTH-1] : v[HALF-1];
   endfunction

   logic             in_full;
   logic [3:0]       in_code;
   logic [WIDTH-1:0] in_mask;
   logic [WIDTH-1:0] a_m;
   logic [WIDTH-1:0] b_m;
   logic             in_shift;

   assign in_full  = bus.FunSel[4];
   assign in_code  = bus.FunSel[3:0];
   assign in_mask  = in_full ? MASK_FULL : MASK_HALF;
   assign a_m      = bus.A & in_mask;
   assign b_m      = bus.B & in_mask;
   assign in_shift = (in_code >= 4'd11);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] op_res;
   logic             op_c;
   logic             op_o;

   always_comb begin
      sum    = '0;
      op_res = '0;
      op_c   = flags[2];
      op_o   = flags[0];
      case (in_code)
         4'd0:  op_res = a_m;
         4'd1:  op_res = b_m;
         4'd2:  op_res = ~a_m & in_mask;
         4'd3:  op_res = ~b_m & in_mask;
         4'd4, 4'd5: begin
            sum    = {1'b0, a_m} + {1'b0, b_m}
                   + {{WIDTH{1'b0}}, (in_code == 4'd5) ? flags[2] : 1'b0};
            op_res = sum[WIDTH-1:0] & in_mask;
            op_c   = in_full ? sum[WIDTH] : sum[HALF];
            op_o   = (msb_of(a_m, in_full) == msb_of(b_m, in_full)) &&
                     (msb_of(op_res, in_full) != msb_of(a_m, in_full));
         end
         4'd6: begin
            op_res = (a_m - b_m) & in_mask;
            op_c   = (a_m >= b_m);
            op_o   = (msb_of(a_m, in_full) != msb_of(b_m, in_full)) &&
                     (msb_of(op_res, in_full) != msb_of(a_m, in_full));
         end
         4'd7:  op_res = a_m & b_m;
         4'd8:  op_res = a_m | b_m;
         4'd9:  op_res = a_m ^ b_m;
         4'd10: op_res = ~(a_m & b_m) & in_mask;
         default: op_res = '0;
      endcase
   end

   // One-bit step of the working register within the captured active width.
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] top_q;
   logic             w_msb;
   logic [WIDTH-1:0] step_res;
   logic             step_out;

   assign mask_q = full_q ? MASK_FULL : MASK_HALF;
   assign top_q  = full_q ? TOP_FULL : TOP_HALF;
   assign w_msb  = msb_of(work, full_q);

   always_comb begin
      step_res = '0;
      step_out = 1'b0;
      case (code_q)
         4'd11: begin
            step_res = (work << 1) & mask_q;
            step_out = w_msb;
         end
         4'd12: begin
            step_res = work >> 1;
            step_out = work[0];
         end
         4'd13: begin
            step_res = (work >> 1) | (w_msb ? top_q : '0);
            step_out = work[0];
         end
         4'd14: begin
            step_res = ((work << 1) | {{(WIDTH-1){1'b0}}, w_msb}) & mask_q;
            step_out = w_msb;
         end
         default: begin
            step_res = (work >> 1) | (work[0] ? top_q : '0);
            step_out = work[0];
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= S_IDLE;
         code_q  <= '0;
         full_q  <= 1'b0;
         wf_q    <= 1'b0;
         work    <= '0;
         cnt     <= '0;
         alu_out <= '0;
         flags   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.InValid) begin
                  code_q <= in_code;
                  full_q <= in_full;
                  wf_q   <= bus.WF;
                  if (in_shift) begin
                     work  <= a_m;
                     cnt   <= (bus.ShAmt == '0) ? SHW'(1) : bus.ShAmt;
                     state <= S_SHIFT;
                  end else begin
                     alu_out <= op_res;
                     if (bus.WF)
                        flags <= {(op_res == '0), op_c, msb_of(op_res, in_full), op_o};
                     state <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               work <= step_res;
               if (cnt == SHW'(1)) begin
                  alu_out <= step_res;
                  if (wf_q)
                     flags <= {(step_res == '0), step_out, msb_of(step_res, full_q), flags[0]};
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - SHW'(1);
               end
            end
            S_DONE: begin
               if (bus.OutReady)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.InReady  = (state == S_IDLE);
   assign bus.OutValid = (state == S_DONE);
   assign bus.ALUOut   = alu_out;
   assign bus.FlagsOut = flags;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expected values.
module tb_alu_seq;
   logic Clock;
   logic Reset;
   int   checks;
   int   failures;
   int   edges;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic wf);
      @(negedge Clock);
      check("in_ready_before_issue", {31'b0, bus.InReady}, 32'd1);
      bus.FunSel  = fs;
      bus.A       = a;
      bus.B       = b;
      bus.ShAmt   = sh;
      bus.WF      = wf;
      bus.InValid = 1'b1;
      @(posedge Clock);
      #1;
      bus.InValid = 1'b0;
   endtask

   task automatic wait_out(input int max_edges, output int n);
      n = 0;
      while (bus.OutValid !== 1'b1 && n < max_edges) begin
         @(posedge Clock);
         #1;
         n++;
      end
      check("out_valid_within_bound", {31'b0, bus.OutValid}, 32'd1);
   endtask

   task automatic release_out();
      @(negedge Clock);
      bus.OutReady = 1'b1;
      @(posedge Clock);
      #1;
      bus.OutReady = 1'b0;
      check("idle_in_ready", {31'b0, bus.InReady}, 32'd1);
      check("idle_out_valid", {31'b0, bus.OutValid}, 32'd0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      Reset        = 1'b0;
      bus.InValid  = 1'b0;
      bus.FunSel   = '0;
      bus.A        = '0;
      bus.B        = '0;
      bus.ShAmt    = '0;
      bus.WF       = 1'b0;
      bus.OutReady = 1'b0;

      #1;
      check("rst_in_ready", {31'b0, bus.InReady}, 32'd1);
      check("rst_out_valid", {31'b0, bus.OutValid}, 32'd0);
      check("rst_alu_out", bus.ALUOut, 32'h0);
      check("rst_flags", {28'b0, bus.FlagsOut}, 32'h0);
      #12;
      Reset = 1'b1;

      // full add with signed overflow
      issue(5'b10100, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b1);
      wait_out(4, edges);
      check("add_latency", edges, 0);
      check("add_result", bus.ALUOut, 32'h8000_0000);
      check("add_flags", {28'b0, bus.FlagsOut}, 32'b0011);
      release_out();

      // half sub with borrow
      issue(5'b00110, 32'hFFFF_0003, 32'h0000_0005, 5'd0, 1'b1);
      wait_out(4, edges);
      check("hsub_result", bus.ALUOut, 32'h0000_FFFE);
      check("hsub_flags", {28'b0, bus.FlagsOut}, 32'b0010);
      release_out();

      // ADC chain: carry from the first add feeds the second
      issue(5'b10100, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1);
      wait_out(4, edges);
      check("adc0_result", bus.ALUOut, 32'h0);
      check("adc0_flags", {28'b0, bus.FlagsOut}, 32'b1100);
      release_out();
      issue(5'b10101, 32'h0, 32'h0, 5'd0, 1'b1);
      wait_out(4, edges);
      check("adc1_result", bus.ALUOut, 32'h1);
      check("adc1_flags", {28'b0, bus.FlagsOut}, 32'b0000);
      release_out();

      // ROL by 4
      issue(5'b11110, 32'h8000_0001, 32'h0, 5'd4, 1'b1);
      check("rol_busy_in_ready", {31'b0, bus.InReady}, 32'd0);
      wait_out(10, edges);
      check("rol_latency", edges, 4);
      check("rol_result", bus.ALUOut, 32'h0000_0018);
      check("rol_flags", {28'b0, bus.FlagsOut}, 32'b0000);
      release_out();

      // LSR with ShAmt=0 behaves as one step
      issue(5'b11100, 32'h3, 32'h0, 5'd0, 1'b1);
      wait_out(10, edges);
      check("lsr0_latency", edges, 1);
      check("lsr0_result", bus.ALUOut, 32'h1);
      check("lsr0_flags", {28'b0, bus.FlagsOut}, 32'b0100);
      release_out();

      // half NOT is zero-extended; WF=0 keeps flags
      issue(5'b00010, 32'h1234_0000, 32'h0, 5'd0, 1'b0);
      wait_out(4, edges);
      check("hnot_result", bus.ALUOut, 32'h0000_FFFF);
      check("hnot_flags_kept", {28'b0, bus.FlagsOut}, 32'b0100);
      release_out();

      // half ASR past the active width gives sign fill
      issue(5'b01101, 32'h0000_8000, 32'h0, 5'd20, 1'b1);
      wait_out(30, edges);
      check("hasr_latency", edges, 20);
      check("hasr_result", bus.ALUOut, 32'h0000_FFFF);
      check("hasr_flags", {28'b0, bus.FlagsOut}, 32'b0110);
      release_out();

      // half ROR by 17 wraps to one effective step but takes 17 cycles
      issue(5'b01111, 32'hABCD_0001, 32'h0, 5'd17, 1'b1);
      wait_out(30, edges);
      check("hror_latency", edges, 17);
      check("hror_result", bus.ALUOut, 32'h0000_8000);
      check("hror_flags", {28'b0, bus.FlagsOut}, 32'b0110);
      release_out();

      // backpressure: AND to zero keeps C, then ignored requests while held
      issue(5'b10111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 1'b1);
      wait_out(4, edges);
      check("and_result", bus.ALUOut, 32'h0);
      check("and_flags", {28'b0, bus.FlagsOut}, 32'b1100);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         bus.A       = ~bus.A;
         bus.B       = 32'h1;
         bus.FunSel  = 5'b10100;
         bus.WF      = 1'b1;
         bus.InValid = 1'b1;
         @(posedge Clock);
         #1;
         check("bp_result_hold", bus.ALUOut, 32'h0);
         check("bp_flags_hold", {28'b0, bus.FlagsOut}, 32'b1100);
         check("bp_in_ready", {31'b0, bus.InReady}, 32'd0);
         check("bp_out_valid", {31'b0, bus.OutValid}, 32'd1);
      end
      @(negedge Clock);
      bus.InValid = 1'b0;
      release_out();
      check("bp_no_ghost_result", bus.ALUOut, 32'h0);

      // async reset in the third cycle of a 10-step shift
      issue(5'b11011, 32'h1, 32'h0, 5'd10, 1'b1);
      @(posedge Clock);
      @(posedge Clock);
      #1;
      check("mid_shift_busy", {30'b0, bus.InReady, bus.OutValid}, 32'd0);
      #2;
      Reset = 1'b0;
      #1;
      check("abort_out_valid", {31'b0, bus.OutValid}, 32'd0);
      check("abort_alu_out", bus.ALUOut, 32'h0);
      check("abort_flags", {28'b0, bus.FlagsOut}, 32'h0);
      check("abort_in_ready", {31'b0, bus.InReady}, 32'd1);
      #2;
      Reset = 1'b1;

      // recovery: half add carrying out of bit 15
      issue(5'b00100, 32'h0000_FFFF, 32'h0000_0001, 5'd0, 1'b1);
      wait_out(4, edges);
      check("hadd_result", bus.ALUOut, 32'h0);
      check("hadd_flags", {28'b0, bus.FlagsOut}, 32'b1100);
      release_out();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
